tff_mod_counter: RTL and testbench

- Parametrised synchronous up/down/load counter built from a bank of toggle flip-flop cells; the next-generation, multi-bit form of the single-bit toggle flip-flop.
- Each bit toggles when its computed T input is 1; the counter wraps at a programmable modulus and flags terminal count.
- Used as a general counter/divider in lab designs, e.g. BCD digits, clock-enable dividers and timers.

---
 rtl/tff_pkg.sv | 11 +
 rtl/toggle_cell.sv | 14 +
 rtl/tff_mod_counter.sv | 84 ++++++++
 tb/tb_tff_mod_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tff_pkg.sv
// Shared mode encodings for the toggle-flip-flop modulus counter.
package tff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_UP   = 2'b01;
  localparam mode_t MODE_DOWN = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/toggle_cell.sv
// Single toggle flip-flop bit with synchronous active-high reset.
module toggle_cell (
  input  logic Clk,
  input  logic rst,
  input  logic T,
  output logic Q
);

  always_ff @(posedge Clk) begin
    if (rst) Q <= 1'b0;
    else     Q <= Q ^ T;
  end

endmodule

// File: rtl/tff_mod_counter.sv
// Up/down/load modulus counter built from a bank of toggle cells.
// Optional Gray-coded output Qg enabled by TFF_MOD_COUNTER_GRAY_OUT_EN.
module tff_mod_counter
  import tff_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             En,
  input  mode_t            Mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Wrap
`ifdef TFF_MOD_COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] Qg
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t_vec;
  logic             wrap_next;

  // Comparisons are written as "< MAX_VAL" so out-of-range values fall into
  // the wrap/saturate branches without needing a constant-max compare.
  always_comb begin
    q_next    = Q;
    wrap_next = 1'b0;
    if (En) begin
      unique case (Mode)
        MODE_UP: begin
          if (Q < MAX_VAL) begin
            q_next = Q + 1'b1;
          end else begin
            q_next    = '0;
            wrap_next = 1'b1;
          end
        end
        MODE_DOWN: begin
          if (Q == '0) begin
            q_next    = MAX_VAL;
            wrap_next = 1'b1;
          end else begin
            q_next = Q - 1'b1;
          end
        end
        MODE_LOAD: q_next = (D < MAX_VAL) ? D : MAX_VAL;
        default:   q_next = Q;
      endcase
    end
  end

  assign t_vec = q_next ^ Q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    toggle_cell u_cell (
      .Clk (Clk),
      .rst (rst),
      .T   (t_vec[i]),
      .Q   (Q[i])
    );
  end

  assign TC = En & (((Mode == MODE_UP) & (Q == MAX_VAL)) |
                    ((Mode == MODE_DOWN) & (Q == '0)));

  always_ff @(posedge Clk) begin
    if (rst) Wrap <= 1'b0;
    else     Wrap <= wrap_next;
  end

`ifdef TFF_MOD_COUNTER_GRAY_OUT_EN
  always_ff @(posedge Clk) begin
    if (rst) Qg <= '0;
    else     Qg <= q_next ^ (q_next >> 1);
  end
`endif

endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed bench for tff_mod_counter (MODULUS=10 and MODULUS=2 instances,
// plus a MODULUS=16 Gray instance when TFF_MOD_COUNTER_GRAY_OUT_EN is set).
module tb_tff_mod_counter;
  import tff_pkg::*;

  logic       Clk = 1'b0;
  logic       rst;
  logic       En;
  mode_t      Mode;
  logic [3:0] D;

  logic [3:0] a_q;
  logic       a_tc, a_wrap;
  logic [1:0] b_q;
  logic       b_tc, b_wrap;

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut_a (
    .Clk(Clk), .rst(rst), .En(En), .Mode(Mode), .D(D),
    .Q(a_q), .TC(a_tc), .Wrap(a_wrap)
`ifdef TFF_MOD_COUNTER_GRAY_OUT_EN
    , .Qg()
`endif
  );

  tff_mod_counter #(.WIDTH(2), .MODULUS(2)) u_dut_b (
    .Clk(Clk), .rst(rst), .En(En), .Mode(Mode), .D(D[1:0]),
    .Q(b_q), .TC(b_tc), .Wrap(b_wrap)
`ifdef TFF_MOD_COUNTER_GRAY_OUT_EN
    , .Qg()
`endif
  );

`ifdef TFF_MOD_COUNTER_GRAY_OUT_EN
  logic [3:0] c_q, c_qg;
  logic       c_tc, c_wrap;
  tff_mod_counter #(.WIDTH(4), .MODULUS(16)) u_dut_c (
    .Clk(Clk), .rst(rst), .En(En), .Mode(Mode), .D(D),
    .Q(c_q), .TC(c_tc), .Wrap(c_wrap), .Qg(c_qg)
  );
`endif

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; En = 1'b1; Mode = MODE_LOAD; D = 4'd5;
    tick();
    total++;
    if (a_q !== 4'd0) $display("FAIL reset_q: got %0d expected 0", a_q); else passed++;
    total++;
    if (a_wrap !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", a_wrap); else passed++;
    total++;
    if (a_tc !== 1'b0) $display("FAIL reset_tc_load: got %b expected 0", a_tc); else passed++;
    Mode = MODE_DOWN;
    #1;
    total++;
    if (a_tc !== 1'b1) $display("FAIL reset_tc_down: got %b expected 1", a_tc); else passed++;
    rst = 1'b0; En = 1'b1; Mode = MODE_UP; D = 4'd0;
    #1;
    total++;
    if (a_tc !== 1'b0) $display("FAIL reset_tc_up: got %b expected 0", a_tc); else passed++;
  endtask

  task automatic test_count_up();
    logic [3:0] exp_q;
    En = 1'b1; Mode = MODE_UP;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_q = 4'((i + 1) % 10);
      total++;
      if (a_q !== exp_q) $display("FAIL up_q[%0d]: got %0d expected %0d", i, a_q, exp_q); else passed++;
      total++;
      if (a_wrap !== (i == 9)) $display("FAIL up_wrap[%0d]: got %b expected %b", i, a_wrap, (i == 9)); else passed++;
      total++;
      if (a_tc !== (exp_q == 4'd9)) $display("FAIL up_tc[%0d]: got %b expected %b", i, a_tc, (exp_q == 4'd9)); else passed++;
    end
  endtask

  task automatic test_load_down();
    logic [3:0] exp_seq [9] = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    En = 1'b1; Mode = MODE_LOAD; D = 4'd7;
    tick();
    total++;
    if (a_q !== 4'd7) $display("FAIL load7_q: got %0d expected 7", a_q); else passed++;
    total++;
    if (a_wrap !== 1'b0) $display("FAIL load7_wrap: got %b expected 0", a_wrap); else passed++;
    Mode = MODE_DOWN;
    for (int i = 0; i < 9; i++) begin
      tick();
      total++;
      if (a_q !== exp_seq[i]) $display("FAIL down_q[%0d]: got %0d expected %0d", i, a_q, exp_seq[i]); else passed++;
      total++;
      if (a_wrap !== (i == 7)) $display("FAIL down_wrap[%0d]: got %b expected %b", i, a_wrap, (i == 7)); else passed++;
      total++;
      if (a_tc !== (exp_seq[i] == 4'd0)) $display("FAIL down_tc[%0d]: got %b expected %b", i, a_tc, (exp_seq[i] == 4'd0)); else passed++;
    end
  endtask

  task automatic test_saturate_hold();
    En = 1'b1; Mode = MODE_LOAD; D = 4'd12;
    tick();
    total++;
    if (a_q !== 4'd9) $display("FAIL sat_q: got %0d expected 9", a_q); else passed++;
    total++;
    if (a_wrap !== 1'b0) $display("FAIL sat_wrap: got %b expected 0", a_wrap); else passed++;
    En = 1'b0; Mode = MODE_UP;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (a_q !== 4'd9) $display("FAIL en0_q[%0d]: got %0d expected 9", i, a_q); else passed++;
      total++;
      if (a_tc !== 1'b0) $display("FAIL en0_tc[%0d]: got %b expected 0", i, a_tc); else passed++;
      total++;
      if (a_wrap !== 1'b0) $display("FAIL en0_wrap[%0d]: got %b expected 0", i, a_wrap); else passed++;
    end
    En = 1'b1; Mode = MODE_HOLD;
    tick();
    total++;
    if (a_q !== 4'd9) $display("FAIL hold_q: got %0d expected 9", a_q); else passed++;
    total++;
    if (a_tc !== 1'b0) $display("FAIL hold_tc: got %b expected 0", a_tc); else passed++;
    Mode = MODE_UP;
    tick();
    total++;
    if (a_wrap !== 1'b1) $display("FAIL wrap_after_hold: got %b expected 1", a_wrap); else passed++;
  endtask

  task automatic test_reset_mid_count();
    En = 1'b1; Mode = MODE_LOAD; D = 4'd4;
    tick();
    Mode = MODE_UP;
    tick();
    total++;
    if (a_q !== 4'd5) $display("FAIL mid_pre_q: got %0d expected 5", a_q); else passed++;
    rst = 1'b1; Mode = MODE_LOAD; D = 4'd3;
    tick();
    total++;
    if (a_q !== 4'd0) $display("FAIL mid_rst_q: got %0d expected 0", a_q); else passed++;
    total++;
    if (a_wrap !== 1'b0) $display("FAIL mid_rst_wrap: got %b expected 0", a_wrap); else passed++;
    rst = 1'b0; Mode = MODE_UP;
    tick();
    total++;
    if (a_q !== 4'd1) $display("FAIL mid_resume_q: got %0d expected 1", a_q); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_q [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
    logic       exp_w [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    tick();
    rst = 1'b0; En = 1'b1; Mode = MODE_UP;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (b_q !== exp_q[i]) $display("FAIL mod2_q[%0d]: got %0d expected %0d", i, b_q, exp_q[i]); else passed++;
      total++;
      if (b_wrap !== exp_w[i]) $display("FAIL mod2_wrap[%0d]: got %b expected %b", i, b_wrap, exp_w[i]); else passed++;
    end
  endtask

`ifdef TFF_MOD_COUNTER_GRAY_OUT_EN
  task automatic test_gray();
    logic [3:0] exp_g [4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
    logic [3:0] prev_g;
    logic [3:0] k;
    rst = 1'b1;
    tick();
    total++;
    if (c_qg !== 4'd0) $display("FAIL gray_reset: got %b expected 0000", c_qg); else passed++;
    rst = 1'b0; En = 1'b1; Mode = MODE_UP;
    prev_g = 4'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      k = 4'((i + 1) % 16);
      if (i < 4) begin
        total++;
        if (c_qg !== exp_g[i]) $display("FAIL gray_seq[%0d]: got %b expected %b", i, c_qg, exp_g[i]); else passed++;
      end
      total++;
      if (c_qg !== (k ^ (k >> 1))) $display("FAIL gray_code[%0d]: got %b expected %b", i, c_qg, k ^ (k >> 1)); else passed++;
      total++;
      if ($countones(c_qg ^ prev_g) != 1) $display("FAIL gray_onebit[%0d]: got %b after %b expected one bit change", i, c_qg, prev_g); else passed++;
      prev_g = c_qg;
    end
  endtask
`endif

  initial begin
    rst = 1'b1; En = 1'b0; Mode = MODE_HOLD; D = 4'd0;
    test_reset();
    test_count_up();
    test_load_down();
    test_saturate_hold();
    test_reset_mid_count();
    test_back_to_back();
`ifdef TFF_MOD_COUNTER_GRAY_OUT_EN
    test_gray();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
